// File: rtl/arbiter_wrr_n_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter family.
// rr_next is the modulo-n increment used by every round-robin scan.
package arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/arbiter_wrr_n_if.sv
// Bundle of the N input streams, the merged output stream and the weights.
// Handshake: a beat moves on a rising edge where valid and ready are both 1; valid never waits on ready.
interface arbiter_wrr_n_if #(
    parameter int N      = 4,
    parameter int DWIDTH = 20,
    parameter int WWIDTH = 4,
    parameter int IDW    = $clog2(N)
);
    import arb_pkg::*;

    logic [N-1:0]              in_valid;
    logic [N-1:0][DWIDTH-1:0]  in_data;
    logic [N-1:0]              in_last;
    logic [N-1:0]              in_ready;
    logic [N-1:0][WWIDTH-1:0]  weight;
    logic                      out_valid;
    logic [DWIDTH-1:0]         out_data;
    logic                      out_last;
    logic [IDW-1:0]            out_id;
    logic                      out_ready;
    arb_state_e                dbg_state;

    modport slave (
        input  in_valid, in_data, in_last, weight, out_ready,
        output in_ready, out_valid, out_data, out_last, out_id, dbg_state
    );

    modport master (
        output in_valid, in_data, in_last, weight, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_id, dbg_state
    );

endinterface

// File: rtl/arbiter_rr_pick.sv
// Combinational round-robin picker: first requester scanning upward from last_gnt+1, wrapping at N.
module arbiter_rr_pick
    import arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last_gnt,
    output logic [IDW-1:0] gnt_idx,
    output logic           any
);

    logic [IDW-1:0] idx;

    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        idx     = IDW'(rr_next(int'(last_gnt), N));
        for (int k = 0; k < N; k++) begin
            if (!any && req[idx]) begin
                any     = 1'b1;
                gnt_idx = idx;
            end
            idx = IDW'(rr_next(int'(idx), N));
        end
    end

endmodule

// File: rtl/arbiter_wrr_n.sv
// N-input weighted round-robin arbiter with packet locking and a one-deep output register slice.
// A grant lasts up to max(weight,1) whole packets; releases early if the owner goes idle between packets.
module arbiter_wrr_n
    import arb_pkg::*;
#(
    parameter int N      = 4,
    parameter int DWIDTH = 20,
    parameter int WWIDTH = 4,
    parameter int IDW    = $clog2(N)
) (
    input logic             clk,
    input logic             rst,
    arbiter_wrr_n_if.slave  bus
);

    arb_state_e        state_q, state_d;
    logic [IDW-1:0]    gnt_q, gnt_d;
    logic [IDW-1:0]    last_gnt_q, last_gnt_d;
    logic [WWIDTH-1:0] credit_q, credit_d;
    logic              pkt_open_q, pkt_open_d;
    logic              out_valid_q, out_valid_d;
    logic [DWIDTH-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic [IDW-1:0]    out_id_q, out_id_d;

    logic [IDW-1:0]    pick_idx;
    logic              pick_any;
    logic [WWIDTH-1:0] wsel;
    logic              accept;
    logic              transfer;

    arbiter_rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req      (bus.in_valid),
        .last_gnt (last_gnt_q),
        .gnt_idx  (pick_idx),
        .any      (pick_any)
    );

    assign wsel     = bus.weight[pick_idx];
    assign accept   = !out_valid_q || bus.out_ready;
    assign transfer = (state_q == BUSY) && bus.in_valid[gnt_q] && accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            last_gnt_q  <= IDW'(N - 1);
            credit_q    <= '0;
            pkt_open_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_gnt_q  <= last_gnt_d;
            credit_q    <= credit_d;
            pkt_open_q  <= pkt_open_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_id_q    <= out_id_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_gnt_d  = last_gnt_q;
        credit_d    = credit_q;
        pkt_open_d  = pkt_open_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_id_d    = out_id_q;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d    = BUSY;
                    gnt_d      = pick_idx;
                    last_gnt_d = pick_idx;
                    credit_d   = (wsel == '0) ? WWIDTH'(1) : wsel;
                    pkt_open_d = 1'b0;
                end
            end
            BUSY: begin
                if (transfer) begin
                    if (bus.in_last[gnt_q]) begin
                        pkt_open_d = 1'b0;
                        credit_d   = credit_q - WWIDTH'(1);
                        if (credit_q == WWIDTH'(1)) state_d = IDLE;
                    end else begin
                        pkt_open_d = 1'b1;
                    end
                end else if (!pkt_open_q && !bus.in_valid[gnt_q]) begin
                    // Owner went quiet between packets: give the bus back, leftover credit is lost.
                    state_d  = IDLE;
                    credit_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (transfer) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.in_data[gnt_q];
            out_last_d  = bus.in_last[gnt_q];
            out_id_d    = gnt_q;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        bus.in_ready = '0;
        if ((state_q == BUSY) && accept) bus.in_ready[gnt_q] = 1'b1;
        bus.out_valid = out_valid_q;
        bus.out_data  = out_data_q;
        bus.out_last  = out_last_q;
        bus.out_id    = out_id_q;
        bus.dbg_state = state_q;
    end

endmodule

// File: doc/arbiter_wrr_n.md
# arbiter_wrr_n

Parametrised N-input weighted round-robin arbiter with packet locking and a registered output stage. It is the successor to the 2-input round-robin arbiter wrappers. It merges N valid/ready streams carrying `last`-delimited packets onto one output stream. A channel keeps the grant for up to its programmed weight in whole packets, and the output is a one-deep register slice so the block closes timing between fabric stages.

## Interface
- `N`, 4: number of input channels, ≥2.
- `DWIDTH`, 20: payload width.
- `WWIDTH`, 4: weight width; max weight 2^WWIDTH−1.
- `IDW`, $clog2(N): width of `out_id`.

- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  [N]  per-channel valid.
- `in_data`  in  [N][DWIDTH]  per-channel payload.
- `in_last`  in  [N]  final beat of a packet.
- `in_ready`  out  [N]  per-channel ready.
- `weight`  in  [N][WWIDTH]  packets per grant; 0 is treated as 1. Sampled at grant.
- `out_valid`  out  1  registered valid.
- `out_data`  out  DWIDTH  registered payload.
- `out_last`  out  1  registered last.
- `out_id`  out  IDW  index of the source channel of the current beat.
- `out_ready`  in  1  downstream ready.

## Operation
- FSM states: `IDLE` (no grant) and `BUSY` (grant held in `gnt`, credit in `credit`, packet-open flag `pkt_open`).
- **IDLE:** if any `in_valid`, pick the first valid channel scanning from `last_gnt+1` mod N upward.
  - Register `gnt`.
  - Set `credit = max(weight[gnt],1)`.
  - Set `last_gnt = gnt`.
  - Go to `BUSY`.
  - No data moves in the IDLE cycle.
- **Slice accept:** `accept = !out_valid || out_ready`.
- **BUSY ready:** `in_ready[i] = (state==BUSY) && (i==gnt) && accept`. All other `in_ready` are 0.
- **Beat transfer:** `in_valid[gnt] && in_ready[gnt]` loads the slice with `out_data`, `out_last`, `out_id=gnt`, and sets `out_valid=1`.
  - If `out_ready && !transfer`, clear `out_valid`.
- **Packet lock:** a transfer with `in_last=0` sets `pkt_open`, and a transfer with `in_last=1` clears it. The grant never changes while `pkt_open=1`, regardless of `in_valid`.
- **End of packet (last beat accepted):** `credit` decrements.
  - If the decremented credit is 0, go to `IDLE`.
  - Otherwise stay in `BUSY` on the same channel.
- **Early release:** in `BUSY` with `pkt_open=0` and `in_valid[gnt]=0`, go to `IDLE` without consuming credit.
- **Single-beat packets:** `in_last=1` on the first beat counts as one packet.
- **Weight changes** while `BUSY` take effect only at the next grant.
- **Arithmetic:** `credit` is WWIDTH bits. It cannot underflow because the floor of 1 is applied at load. `last_gnt+1` wraps N−1→0, correct for non-power-of-2 N.

## Timing
- **Reset values:**
  - `out_valid=0`, `out_data=0`, `out_last=0`, `out_id=0`.
  - `in_ready` all 0.
  - state `IDLE`, `pkt_open=0`, `credit=0`.
  - `last_gnt=N−1`, so channel 0 has top priority on the first arbitration.
- **Latency:**
  - First beat after IDLE: `in_valid` at cycle t → grant at t+1 → `in_ready` at t+1 → `out_valid` at t+2.
  - Steady state within a grant: 1 cycle, one beat per cycle at full throughput.
- **Handoff bubble:** regrant costs exactly one idle cycle (IDLE) between grants.
- **Backpressure:** when `out_ready=0` and `out_valid=1`, `in_ready=0` the same cycle (combinational through `accept`). The slice holds its data stable.
- **Reset mid-packet:** everything returns to reset values on the next edge. Any partial packet is dropped, and the source is responsible for re-issuing it.
- **Simultaneous valid requests in IDLE:** strict rotation order from `last_gnt+1`.

## Structure
- Package `arb_pkg`:
  - `arb_state_e` enum {`IDLE`, `BUSY`}.
  - function `rr_next(idx, n)` implementing the modulo-N increment.
- Sub-module `arbiter_rr_pick #(N)`:
  - combinational round-robin picker with inputs `req[N]`, `last_gnt`, and outputs `gnt_idx`, `any`.
  - reused by `arbiter_wrr_n` and by existing 2-port wrappers.
- Top `arbiter_wrr_n` holds the FSM, credit counter, packet lock, and output slice.

## Test plan
- **Rotation:** N=4, all weights 1, all channels continuously send 1-beat packets with `out_ready=1` → `out_id` sequence 0,1,2,3,0,…, with one bubble cycle between each beat.
- **Weighting:** weights {3,1,1,1}, channels 0 and 2 saturated → per 4 granted packets, `out_id` = 0,0,0,2, repeating. Weight 0 on channel 2 behaves as 1.
- **Packet lock:** channel 1 sends a 5-beat packet, channel 0 asserts valid at beat 2 → all 5 beats are `out_id=1` contiguous, and channel 0 is granted after the bubble.
- **Backpressure:** `out_ready` toggles 1,0,0,1 during a 4-beat packet → no beat lost or duplicated, `out_data` stable while stalled, and order is preserved.
- **Early release:** channel 3 has weight 4 but sends one packet then drops valid → block returns to IDLE and grants channel 0 next. `credit` is discarded.
- **Reset:** assert `rst` for one cycle mid-packet on channel 2 → next cycle all outputs are 0, and first post-reset grant goes to the lowest valid channel starting from 0.
